// File: rtl/gcd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gcd_ctrl                                                        |
// | Purpose  : Control FSM for a subtractive GCD datapath. Loads operands A    |
// |            and B from the shared bus, iterates A-=B / B-=A steps until    |
// |            the datapath reports equality, then pulses done. The result    |
// |            is left in datapath register A. A watchdog bounds the number   |
// |            of subtract steps.                                             |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            start      - request a run (sampled in IDLE only)              |
// |            data_in    - shared operand bus (zero detection only)          |
// |            gt/lt/eq   - datapath compare flags                            |
// |            ldA/ldB    - datapath register load enables                    |
// |            sel1/sel2  - subtractor minuend/subtrahend select (0=A, 1=B)   |
// |            sel_in     - bus select (1=data_in, 0=subtractor)              |
// |            busy/done  - host handshake                                    |
// |            err        - run aborted (watchdog or both operands zero)      |
// |            iter_count - subtract steps in the last/current run            |
// | Options  : GCD_CTRL_ZERO_GUARD_EN - zero-operand detection and FIX state  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module gcd_ctrl #(
  parameter int WIDTH    = 16,
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 2**CNT_W-1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic             ldA,
  output logic             ldB,
  output logic             sel1,
  output logic             sel2,
  output logic             sel_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_count
);

  localparam logic [CNT_W-1:0] c_max_iter = CNT_W'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
`ifdef GCD_CTRL_ZERO_GUARD_EN
    , S_FIX  = 3'd5
`endif
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_iter;
  logic             r_err;

  logic w_accept;   // start accepted in IDLE: clear per-run status
  logic w_inc;      // one subtract step issued this cycle
  logic w_set_err;  // abort condition reached this cycle
  logic w_zguard;   // a zero operand was seen; bypass the subtract loop

  // Only a single asserted flag is a real step request; anything else
  // (none, or several) ends the loop as if the registers were equal.
  logic w_gt_only;
  logic w_lt_only;
  assign w_gt_only = gt & ~lt & ~eq;
  assign w_lt_only = lt & ~gt & ~eq;

`ifdef GCD_CTRL_ZERO_GUARD_EN
  // Zero flags are registered, so the zero decision is taken in the first
  // RUN cycle rather than combinationally at the end of LOAD_B.
  logic r_za;
  logic r_zb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_za <= 1'b0;
      r_zb <= 1'b0;
    end else if (w_accept) begin
      r_za <= 1'b0;
      r_zb <= 1'b0;
    end else if (r_state == S_LOAD_A) begin
      r_za <= (data_in == '0);
    end else if (r_state == S_LOAD_B) begin
      r_zb <= (data_in == '0);
    end
  end

  assign w_zguard = r_za | r_zb;
`else
  // The bus is not observed when the zero guard is compiled out.
  logic w_unused;
  assign w_unused = ^data_in;
  assign w_zguard = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_iter <= '0;
        r_err  <= 1'b0;
      end else begin
        if (w_inc) begin
          r_iter <= r_iter + CNT_W'(1);
        end
        if (w_set_err) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    ldA       = 1'b0;
    ldB       = 1'b0;
    sel1      = 1'b0;
    sel2      = 1'b0;
    sel_in    = 1'b0;
    w_accept  = 1'b0;
    w_inc     = 1'b0;
    w_set_err = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_LOAD_A;
        end
      end

      S_LOAD_A: begin
        sel_in = 1'b1;
        ldA    = 1'b1;
        w_next = S_LOAD_B;
      end

      S_LOAD_B: begin
        sel_in = 1'b1;
        ldB    = 1'b1;
        w_next = S_RUN;
      end

      S_RUN: begin
        if (w_zguard) begin
`ifdef GCD_CTRL_ZERO_GUARD_EN
          if (r_za && r_zb) begin
            w_set_err = 1'b1;
            w_next    = S_DONE;
          end else if (r_zb) begin
            // B == 0: A already holds gcd(A, 0) = A.
            w_next = S_DONE;
          end else begin
            w_next = S_FIX;
          end
`endif
        end else if (!(w_gt_only || w_lt_only)) begin
          w_next = S_DONE;
        end else if (r_iter == c_max_iter) begin
          // Watchdog: refuse further steps, which also keeps iter_count
          // from ever wrapping.
          w_set_err = 1'b1;
          w_next    = S_DONE;
        end else begin
          sel1  = w_lt_only;
          sel2  = w_gt_only;
          ldA   = w_gt_only;
          ldB   = w_lt_only;
          w_inc = 1'b1;
        end
      end

`ifdef GCD_CTRL_ZERO_GUARD_EN
      S_FIX: begin
        // A == 0: copy B into A via B - A (= B - 0); not an iteration.
        sel1   = 1'b1;
        sel2   = 1'b0;
        ldA    = 1'b1;
        w_next = S_DONE;
      end
`endif

      S_DONE: begin
        w_next = S_IDLE;
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign err        = r_err;
  assign iter_count = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_gcd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_gcd_ctrl                                                     |
// | Purpose  : Self-checking bench for gcd_ctrl with a behavioural subtractive |
// |            GCD datapath. Watchdog limit is 3 so it can be reached.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_gcd_ctrl;

  localparam int WIDTH    = 16;
  localparam int CNT_W    = 4;
  localparam int MAX_ITER = 3;
  localparam int TIMEOUT  = 30;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             gt, lt, eq;
  logic             ldA, ldB, sel1, sel2, sel_in, busy, done, err;
  logic [CNT_W-1:0] iter_count;

  int n_checks;
  int n_pass;

  gcd_ctrl #(
    .WIDTH   (WIDTH),
    .CNT_W   (CNT_W),
    .MAX_ITER(MAX_ITER)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_in   (data_in),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq),
    .ldA       (ldA),
    .ldB       (ldB),
    .sel1      (sel1),
    .sel2      (sel2),
    .sel_in    (sel_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .iter_count(iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: registers A/B, shared subtractor, compare flags.
  logic [WIDTH-1:0] dp_a, dp_b, dp_sub;
  assign dp_sub = (sel1 ? dp_b : dp_a) - (sel2 ? dp_b : dp_a);
  assign gt = (dp_a > dp_b);
  assign lt = (dp_a < dp_b);
  assign eq = (dp_a == dp_b);

  initial begin
    dp_a = '0;
    dp_b = '0;
  end

  always @(posedge clk) begin
    if (ldA) dp_a <= sel_in ? data_in : dp_sub;
    if (ldB) dp_b <= sel_in ? data_in : dp_sub;
  end

  // One full run. Returns the cycle index (relative to accept edge E0) in
  // which done is seen, the number of load pulses after LOAD_B, and the
  // handshake/status observed during LOAD_A. Returns at the negedge of the
  // done cycle. If poke is set, start is pulsed during RUN cycle 3.
  task automatic run_gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit poke, output int dcyc, output int lds,
                         output bit load_ok, output bit cleared_ok);
    int k;
    @(posedge clk);
    #1 start = 1'b1; data_in = '0;
    @(posedge clk);                       // E0: accept
    #1 start = 1'b0; data_in = a;
    @(negedge clk);
    load_ok    = ldA && sel_in && busy && !ldB && !done;
    cleared_ok = (err == 1'b0) && (iter_count == '0);
    @(posedge clk);                       // E1: LOAD_B
    #1 data_in = b;
    @(posedge clk);                       // E2
    #1 data_in = '0;
    k    = 2;
    dcyc = -1;
    lds  = 0;
    while (k < TIMEOUT) begin
      @(negedge clk);
      if (done) begin
        dcyc = k;
        break;
      end
      lds = lds + int'(ldA) + int'(ldB);
      @(posedge clk);
      k = k + 1;
      #1 start = (poke && k == 3);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ldA, ldB, sel1, sel2, sel_in, busy, done, err} !== 8'b0)
      $display("FAIL reset_outputs: got %b expected 00000000",
               {ldA, ldB, sel1, sel2, sel_in, busy, done, err});
    else n_pass++;
    n_checks++;
    if (iter_count !== '0) $display("FAIL reset_iter: got %0d expected 0", iter_count);
    else n_pass++;
  endtask

  task automatic test_gcd_12_8;
    int dcyc, lds; bit lok, cok;
    run_gcd(16'd12, 16'd8, 1'b0, dcyc, lds, lok, cok);
    n_checks++;
    if (lok !== 1'b1) $display("FAIL gcd12_8_load_a: outputs wrong in LOAD_A");
    else n_pass++;
    n_checks++;
    if (dcyc !== 5) $display("FAIL gcd12_8_latency: got %0d expected 5", dcyc);
    else n_pass++;
    n_checks++;
    if (iter_count !== 4'd2 || err !== 1'b0)
      $display("FAIL gcd12_8_status: iter %0d err %b expected iter 2 err 0", iter_count, err);
    else n_pass++;
    n_checks++;
    if (dp_a !== 16'd4) $display("FAIL gcd12_8_result: got %0d expected 4", dp_a);
    else n_pass++;
    n_checks++;
    if (lds !== 2) $display("FAIL gcd12_8_steps: got %0d loads expected 2", lds);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL done_single_cycle: done %b busy %b expected 0 0", done, busy);
    else n_pass++;
  endtask

  task automatic test_equal;
    int dcyc, lds; bit lok, cok;
    run_gcd(16'd7, 16'd7, 1'b0, dcyc, lds, lok, cok);
    n_checks++;
    if (dcyc !== 3) $display("FAIL equal_latency: got %0d expected 3", dcyc);
    else n_pass++;
    n_checks++;
    if (iter_count !== 4'd0 || lds !== 0 || err !== 1'b0)
      $display("FAIL equal_status: iter %0d loads %0d err %b expected 0 0 0",
               iter_count, lds, err);
    else n_pass++;
    n_checks++;
    if (dp_a !== 16'd7) $display("FAIL equal_result: got %0d expected 7", dp_a);
    else n_pass++;
  endtask

  task automatic test_watchdog;
    int dcyc, lds; bit lok, cok;
    run_gcd(16'd100, 16'd1, 1'b0, dcyc, lds, lok, cok);
    n_checks++;
    if (dcyc !== 6) $display("FAIL watchdog_latency: got %0d expected 6", dcyc);
    else n_pass++;
    n_checks++;
    if (err !== 1'b1 || iter_count !== 4'd3)
      $display("FAIL watchdog_status: err %b iter %0d expected err 1 iter 3", err, iter_count);
    else n_pass++;
    n_checks++;
    if (dp_a !== 16'd97) $display("FAIL watchdog_reg_a: got %0d expected 97", dp_a);
    else n_pass++;
  endtask

  // Called directly after test_watchdog: start lands in the cycle after done.
  task automatic test_back_to_back;
    int dcyc, lds; bit lok, cok;
    run_gcd(16'd12, 16'd8, 1'b1, dcyc, lds, lok, cok);
    n_checks++;
    if (cok !== 1'b1) $display("FAIL b2b_clear: err/iter not cleared on accept");
    else n_pass++;
    n_checks++;
    if (dcyc !== 5) $display("FAIL busy_start_latency: got %0d expected 5", dcyc);
    else n_pass++;
    n_checks++;
    if (iter_count !== 4'd2 || err !== 1'b0 || dp_a !== 16'd4)
      $display("FAIL busy_start_status: iter %0d err %b A %0d expected 2 0 4",
               iter_count, err, dp_a);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL busy_start_idle: busy %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_zero;
    int dcyc, lds; bit lok, cok;
`ifdef GCD_CTRL_ZERO_GUARD_EN
    run_gcd(16'd0, 16'd9, 1'b0, dcyc, lds, lok, cok);
    n_checks++;
    if (dcyc !== 4) $display("FAIL zero_a_latency: got %0d expected 4", dcyc);
    else n_pass++;
    n_checks++;
    if (dp_a !== 16'd9 || err !== 1'b0 || iter_count !== 4'd0)
      $display("FAIL zero_a_status: A %0d err %b iter %0d expected 9 0 0",
               dp_a, err, iter_count);
    else n_pass++;
    run_gcd(16'd9, 16'd0, 1'b0, dcyc, lds, lok, cok);
    n_checks++;
    if (dcyc !== 3 || dp_a !== 16'd9 || err !== 1'b0)
      $display("FAIL zero_b: cycle %0d A %0d err %b expected 3 9 0", dcyc, dp_a, err);
    else n_pass++;
    run_gcd(16'd0, 16'd0, 1'b0, dcyc, lds, lok, cok);
    n_checks++;
    if (dcyc !== 3 || err !== 1'b1)
      $display("FAIL zero_both: cycle %0d err %b expected 3 1", dcyc, err);
    else n_pass++;
`else
    run_gcd(16'd0, 16'd9, 1'b0, dcyc, lds, lok, cok);
    n_checks++;
    if (dcyc !== 6) $display("FAIL zero_a_latency: got %0d expected 6", dcyc);
    else n_pass++;
    n_checks++;
    if (err !== 1'b1 || iter_count !== 4'd3)
      $display("FAIL zero_a_status: err %b iter %0d expected 1 3", err, iter_count);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_midrun;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);                       // E0
    #1 start = 1'b0; data_in = 16'd100;
    @(posedge clk);                       // E1
    #1 data_in = 16'd1;
    @(posedge clk);                       // E2: RUN
    #1 data_in = '0;
    @(posedge clk);                       // E3: still RUN, stepping
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || ldA !== 1'b1)
      $display("FAIL midrun_active: busy %b ldA %b expected 1 1", busy, ldA);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ldA, ldB, sel1, sel2, sel_in, busy, done, err} !== 8'b0 || iter_count !== '0)
      $display("FAIL midrun_reset: outputs %b iter %0d expected all 0",
               {ldA, ldB, sel1, sel2, sel_in, busy, done, err}, iter_count);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL midrun_idle: busy %b done %b expected 0 0", busy, done);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    data_in  = '0;
    test_reset();
    test_gcd_12_8();
    test_equal();
    test_watchdog();
    test_back_to_back();
    test_zero();
    test_reset_midrun();
    test_gcd_12_8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
